pkt_ram_arbiter: RTL

- Shares the single read port of the packet RAM between NUM_REQ requesters: parser stages, the tag fetch path and the reconfiguration loader.
- Arbitrates round-robin and issues one RAM address per cycle.
- Tracks each read through the RAM's fixed read latency and steers returned data back to the requester that issued it.
- Provides a lock/drain handshake so the control plane can quiesce RAM reads before reconfiguring or rewriting the RAM.

---
 rtl/pkt_ram_arbiter_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/pkt_ram_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/pkt_ram_arbiter_pkg.sv
// Shared types and defaults for the packet RAM read-port arbiter.
// Widths, default read latency, FSM states and the in-flight read tag.
package pkt_ram_arbiter_pkg;

  localparam int PKT_ADDR_WIDTH = 8;
  localparam int PKT_DATA_WIDTH = 16;
  localparam int PKT_RAM_RD_LAT = 1;
  localparam int TAG_ID_W       = 3;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after
// the pointer, wrapping, wins. Reusable by other switch arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      automatic int j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_ram_arbiter.sv
// Round-robin arbiter for the packet RAM read port with read-return
// steering and a lock/drain handshake for the control plane.
module pkt_ram_arbiter
  import pkt_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = PKT_ADDR_WIDTH,
  parameter int DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int RD_LAT     = PKT_RAM_RD_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  input  logic [DATA_WIDTH-1:0]         ram_data_i,
  input  logic                          lock_req_i,
  output logic                          lock_ack_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  rd_tag_t               pipe_q [RD_LAT];
  rd_tag_t               out_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               win;
  logic               busy;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // A lock request blocks the grant in the very cycle it rises.
  assign win = (state_q == ARB_RUN) && !lock_req_i && pick_vld;

  assign gnt_o      = (rst && win) ? pick_gnt : '0;
  assign ram_addr_o = (rst && win)
                    ? req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                    : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (win) begin
      if (int'(pick_idx) == NUM_REQ - 1) ptr_d = '0;
      else ptr_d = pick_idx + IW'(1);
    end
  end

  always_comb begin
    busy = out_q.vld;
    for (int i = 0; i < RD_LAT; i++) busy = busy | pipe_q[i].vld;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_RUN:
        if (lock_req_i) state_d = ARB_DRAIN;
      ARB_DRAIN:
        if (!lock_req_i) state_d = ARB_RUN;
        else if (!busy) state_d = ARB_LOCKED;
      ARB_LOCKED:
        if (!lock_req_i) state_d = ARB_RUN;
      default:
        state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_RUN;
      ptr_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      out_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pipe_q[0] <= '{vld: win, id: TAG_ID_W'(pick_idx)};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      out_q <= pipe_q[RD_LAT-1];
      if (pipe_q[RD_LAT-1].vld) rdata_q <= ram_data_i;
    end
  end

  assign rvalid_o   = out_q.vld ? (NUM_REQ'(1) << out_q.id) : '0;
  assign rdata_o    = rdata_q;
  assign lock_ack_o = (state_q == ARB_LOCKED);

endmodule
